// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Sequencing controller for the DE10 stopwatch. Conditions three raw
//   active-low pushbuttons into single-cycle press events, runs the
//   IDLE/RUN/PAUSE/LAP machine, generates the 0.1 s time base and keeps the
//   BCD seconds counters that feed the seven-segment decoder.
//
// Parameters
//   TICK_CYCLES : clock cycles per 0.1 s tick
//   DB_CYCLES   : consecutive stable synchronized cycles to accept a level change
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   key_start_n : raw start/stop button (active low, asynchronous)
//   key_lap_n   : raw lap button (active low)
//   key_clear_n : raw clear button (active low)
//   tens_sec    : displayed tens of seconds, 0-5
//   ones_sec    : displayed ones of seconds, 0-9
//   tenth_sec   : displayed tenths, 0-9
//   running     : high in RUN and LAP
//   lap_active  : high in LAP (display frozen)
//   overflow    : sticky, set when the count wraps past 59.9
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned TICK_CYCLES = 5_000_000,
    parameter int unsigned DB_CYCLES   = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       key_clear_n,
    output logic [2:0] tens_sec,
    output logic [3:0] ones_sec,
    output logic [3:0] tenth_sec,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    localparam int unsigned B_START = 0;
    localparam int unsigned B_LAP   = 1;
    localparam int unsigned B_CLEAR = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_LAP
    } state_t;

    // -------------------------------------------------------------------------
    // Button conditioning: 2-flop synchronizer, debounce counter, press pulse
    // -------------------------------------------------------------------------
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_db;
    logic [2:0]    r_press;
    logic [DW-1:0] r_dbcnt [3];

    assign w_raw = {key_clear_n, key_lap_n, key_start_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            r_press <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_dbcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_db[i]) begin
                    r_dbcnt[i] <= '0;
                end else if (r_dbcnt[i] == DB_LAST) begin
                    r_db[i]    <= r_sync2[i];
                    r_dbcnt[i] <= '0;
                    // Old level 1 means this flip is 1->0, i.e. a press.
                    r_press[i] <= r_db[i];
                end else begin
                    r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Time base and next live count
    // -------------------------------------------------------------------------
    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_tens;
    logic [3:0]    r_ones;
    logic [3:0]    r_tenth;
    logic [2:0]    r_disp_tens;
    logic [3:0]    r_disp_ones;
    logic [3:0]    r_disp_tenth;
    logic          r_running;
    logic          r_lap_active;
    logic          r_overflow;

    logic          w_counting;
    logic          w_tick;
    logic [2:0]    w_tens_n;
    logic [3:0]    w_ones_n;
    logic [3:0]    w_tenth_n;
    logic          w_wrap;

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == PRESC_LAST);

    always_comb begin
        w_tens_n  = r_tens;
        w_ones_n  = r_ones;
        w_tenth_n = r_tenth;
        w_wrap    = 1'b0;
        if (w_tick) begin
            if (r_tenth == 4'd9) begin
                w_tenth_n = '0;
                if (r_ones == 4'd9) begin
                    w_ones_n = '0;
                    if (r_tens == 3'd5) begin
                        w_tens_n = '0;
                        w_wrap   = 1'b1;
                    end else begin
                        w_tens_n = r_tens + 3'd1;
                    end
                end else begin
                    w_ones_n = r_ones + 4'd1;
                end
            end else begin
                w_tenth_n = r_tenth + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    // Counting is decided by the current state, so a tick on a transition edge
    // is always consumed before the new state takes effect. The display
    // register doubles as the lap snapshot: it simply stops following the live
    // count while in LAP.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_tens       <= '0;
            r_ones       <= '0;
            r_tenth      <= '0;
            r_disp_tens  <= '0;
            r_disp_ones  <= '0;
            r_disp_tenth <= '0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_tens       <= w_tens_n;
            r_ones       <= w_ones_n;
            r_tenth      <= w_tenth_n;
            r_overflow   <= r_overflow | w_wrap;
            r_disp_tens  <= w_tens_n;
            r_disp_ones  <= w_ones_n;
            r_disp_tenth <= w_tenth_n;
            if (w_counting) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    if (r_press[B_START]) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_press[B_START]) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end else if (r_press[B_LAP]) begin
                        r_state      <= S_LAP;
                        r_lap_active <= 1'b1;
                        // Snapshot takes the pre-increment value.
                        r_disp_tens  <= r_tens;
                        r_disp_ones  <= r_ones;
                        r_disp_tenth <= r_tenth;
                    end
                end
                S_LAP: begin
                    if (r_press[B_START]) begin
                        r_state      <= S_PAUSE;
                        r_running    <= 1'b0;
                        r_lap_active <= 1'b0;
                    end else if (r_press[B_LAP]) begin
                        r_state      <= S_RUN;
                        r_lap_active <= 1'b0;
                    end else begin
                        r_disp_tens  <= r_disp_tens;
                        r_disp_ones  <= r_disp_ones;
                        r_disp_tenth <= r_disp_tenth;
                    end
                end
                S_PAUSE: begin
                    if (r_press[B_START]) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else if (r_press[B_CLEAR]) begin
                        r_state      <= S_IDLE;
                        r_presc      <= '0;
                        r_tens       <= '0;
                        r_ones       <= '0;
                        r_tenth      <= '0;
                        r_disp_tens  <= '0;
                        r_disp_ones  <= '0;
                        r_disp_tenth <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tens_sec   = r_disp_tens;
    assign ones_sec   = r_disp_ones;
    assign tenth_sec  = r_disp_tenth;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed scenarios followed by random button activity, all compared each
//   cycle against a behavioural model that tracks the count as a single
//   integer of tenths and accepts a button level once its last DB_CYCLES
//   synchronized samples all disagree with the accepted level.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TICK = 4;
    localparam int DB   = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start_n;
    logic       key_lap_n;
    logic       key_clear_n;
    logic [2:0] tens_sec;
    logic [3:0] ones_sec;
    logic [3:0] tenth_sec;
    logic       running;
    logic       lap_active;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(
        .TICK_CYCLES(TICK),
        .DB_CYCLES  (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_start_n(key_start_n),
        .key_lap_n  (key_lap_n),
        .key_clear_n(key_clear_n),
        .tens_sec   (tens_sec),
        .ones_sec   (ones_sec),
        .tenth_sec  (tenth_sec),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int       m_mode;
    int       m_count;   // tenths since clear, 0..599
    int       m_phase;   // cycles into the current tenth
    int       m_snap;
    bit       m_ovf;
    bit [2:0] m_db;      // accepted levels {clear, lap, start}
    bit [2:0] m_ev;      // press events to act on at the next edge
    bit [2:0] m_p0;
    bit [2:0] m_p1;
    bit [2:0] m_hist [DB];
    int       m_nv;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_count = 0;
        m_phase = 0;
        m_snap  = 0;
        m_ovf   = 1'b0;
        m_db    = '1;
        m_ev    = '0;
        m_p0    = '1;
        m_p1    = '1;
        m_nv    = 0;
        for (int j = 0; j < DB; j++) m_hist[j] = '0;
    endtask

    task automatic model_edge();
        bit [2:0] raw;
        bit [2:0] samp;
        bit [2:0] stable;
        bit       counting;
        bit       tick;
        int       old_count;
        raw       = {key_clear_n, key_lap_n, key_start_n};
        counting  = (m_mode == M_RUN) || (m_mode == M_LAP);
        tick      = counting && (m_phase == TICK - 1);
        old_count = m_count;
        if (counting) m_phase = (m_phase + 1) % TICK;
        if (tick) begin
            if (m_count == 599) m_ovf = 1'b1;
            m_count = (m_count + 1) % 600;
        end
        case (m_mode)
            M_IDLE:  if (m_ev[0]) m_mode = M_RUN;
            M_RUN:   if (m_ev[0]) m_mode = M_PAUSE;
                     else if (m_ev[1]) begin m_mode = M_LAP; m_snap = old_count; end
            M_LAP:   if (m_ev[0]) m_mode = M_PAUSE;
                     else if (m_ev[1]) m_mode = M_RUN;
            default: if (m_ev[0]) m_mode = M_RUN;
                     else if (m_ev[2]) begin
                         m_mode = M_IDLE; m_count = 0; m_phase = 0; m_ovf = 1'b0;
                     end
        endcase
        // raw level reaches the debouncer two edges later
        samp = m_p0;
        m_p0 = m_p1;
        m_p1 = raw;
        for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = samp;
        if (m_nv < DB) m_nv++;
        stable = '1;
        for (int j = 0; j < DB; j++) stable &= (m_hist[j] ^ m_db);
        if (m_nv < DB) stable = '0;
        m_ev = stable & m_db;
        m_db = m_db ^ stable;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] disp_obs();
        return 32'({1'b0, tens_sec, ones_sec, tenth_sec});
    endfunction

    task automatic model_check();
        int d;
        d = (m_mode == M_LAP) ? m_snap : m_count;
        check("digits", disp_obs(), 32'((d / 100) * 256 + ((d / 10) % 10) * 16 + (d % 10)));
        check("running", 32'(running), 32'((m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0));
        check("lap_active", 32'(lap_active), 32'((m_mode == M_LAP) ? 1 : 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // mask bits: 0 start, 1 lap, 2 clear; the state acts on the 6th edge
    task automatic press(input logic [2:0] mask);
        {key_clear_n, key_lap_n, key_start_n} = ~mask;
        run(4);
        {key_clear_n, key_lap_n, key_start_n} = 3'b111;
        run(2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits"}, disp_obs(), 32'h000);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_lap"}, 32'(lap_active), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    int       hold [3];
    bit [2:0] lvl;

    initial begin
        rst_n = 1'b0;
        {key_clear_n, key_lap_n, key_start_n} = 3'b111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // 2-cycle glitch rejected, 3+ cycle low accepted exactly on edge 3+DB
        key_start_n = 1'b0;
        run(2);
        key_start_n = 1'b1;
        run(10);
        check("glitch_running", 32'(running), 32'd0);
        key_start_n = 1'b0;
        run(4);
        key_start_n = 1'b1;
        run(1);
        check("db_early", 32'(running), 32'd0);
        run(1);
        check("db_edge", 32'(running), 32'd1);

        // count, carry and wrap
        run(160);
        check("count_40", disp_obs(), 32'h040);
        run(2236);
        check("count_599", disp_obs(), 32'h599);
        check("ovf_before_wrap", 32'(overflow), 32'd0);
        run(4);
        check("wrap_digits", disp_obs(), 32'h000);
        check("wrap_ovf", 32'(overflow), 32'd1);

        // pause two cycles into a tenth, resume finishes the remaining two
        press(3'b001);
        check("pause_running", 32'(running), 32'd0);
        check("pause_digits", disp_obs(), 32'h001);
        run(100);
        check("pause_hold", disp_obs(), 32'h001);
        press(3'b001);
        check("resume_running", 32'(running), 32'd1);
        run(1);
        check("resume_partial", disp_obs(), 32'h001);
        run(1);
        check("resume_tick", disp_obs(), 32'h002);

        // lap freeze and release
        run(40);
        press(3'b010);
        check("lap_enter", disp_obs(), 32'h013);
        check("lap_active_on", 32'(lap_active), 32'd1);
        run(74);
        check("lap_frozen", disp_obs(), 32'h013);
        check("lap_still", 32'(lap_active), 32'd1);
        press(3'b010);
        check("lap_exit", disp_obs(), 32'h033);
        check("lap_active_off", 32'(lap_active), 32'd0);

        // clear ignored while running; start beats clear in PAUSE
        press(3'b100);
        check("clear_in_run", 32'(running), 32'd1);
        run(4);
        press(3'b001);
        check("pause2", 32'(running), 32'd0);
        run(4);
        press(3'b101);
        check("start_over_clear", 32'(running), 32'd1);
        run(4);
        press(3'b001);
        run(4);
        check("ovf_sticky", 32'(overflow), 32'd1);
        press(3'b100);
        check_zero("clear");
        run(4);

        // asynchronous reset mid-count, then only start restarts
        press(3'b001);
        run(20);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        press(3'b010);
        run(4);
        press(3'b100);
        run(4);
        check("post_reset_idle", 32'(running), 32'd0);
        press(3'b001);
        check("post_reset_start", 32'(running), 32'd1);
        run(12);
        check("post_reset_count", disp_obs(), 32'h003);

        // random button activity with glitches and overlapping presses
        for (int b = 0; b < 3; b++) hold[b] = 0;
        lvl = 3'b111;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = 1'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 10));
                end
                hold[b]--;
            end
            {key_clear_n, key_lap_n, key_start_n} = lvl;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
